// File: rtl/alu_exec.sv
// Multi-cycle 16-bit ALU: one operation per start, shifts/rotates step one bit per cycle.
// Results and flags are registered and held until the next done pulse.
module alu_exec (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic        inv_a,
  input  logic        inv_b,
  input  logic        cin,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        cout,
  output logic        ofl,
  output logic        zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [3:0] code);
    return (code[3:2] == 2'b00);
  endfunction

  function automatic logic [15:0] shift_step(input logic [1:0] kind, input logic [15:0] w);
    logic [15:0] r;
    case (kind)
      2'b00:   r = {w[14:0], w[15]};
      2'b01:   r = {w[14:0], 1'b0};
      2'b10:   r = {w[0], w[15:1]};
      2'b11:   r = {1'b0, w[15:1]};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] bit_reverse(input logic [15:0] w);
    logic [15:0] r;
    r = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      r[i] = w[15-i];
    end
    return r;
  endfunction

  state_t      state_r;
  state_t      next_s;

  logic [3:0]  op_r;
  logic        inv_a_r;
  logic        inv_b_r;
  logic        cin_r;
  logic [15:0] a_r;
  logic [15:0] b_r;
  logic [15:0] work_r;
  logic [3:0]  count_r;

  logic [3:0]  op_s;
  logic        inv_a_s;
  logic        inv_b_s;
  logic        cin_s;
  logic [15:0] a_s;
  logic [15:0] b_s;
  logic [15:0] ap_s;
  logic [15:0] bp_s;
  logic [16:0] sum_s;
  logic        ofl_s;
  logic [15:0] alu_s;
  logic [15:0] step_s;
  logic [15:0] final_s;

  // Operand source: live inputs while idle (single-cycle ops finish on the start edge), latched copy otherwise
  always_comb begin
    op_s    = op_r;
    inv_a_s = inv_a_r;
    inv_b_s = inv_b_r;
    cin_s   = cin_r;
    a_s     = a_r;
    b_s     = b_r;
    if (state_r == IDLE) begin
      op_s    = op;
      inv_a_s = inv_a;
      inv_b_s = inv_b;
      cin_s   = cin;
      a_s     = a;
      b_s     = b;
    end else begin
      op_s    = op_r;
      inv_a_s = inv_a_r;
      inv_b_s = inv_b_r;
      cin_s   = cin_r;
      a_s     = a_r;
      b_s     = b_r;
    end
  end

  // Operand conditioning, adder and its flags
  always_comb begin
    ap_s  = inv_a_s ? ~a_s : a_s;
    bp_s  = inv_b_s ? ~b_s : b_s;
    sum_s = {1'b0, ap_s} + {1'b0, bp_s} + {16'h0000, cin_s};
    ofl_s = (ap_s[15] == bp_s[15]) && (sum_s[15] != ap_s[15]);
  end

  // Single-cycle result; shift ops here only cover amount 0, which returns A' unchanged
  always_comb begin
    alu_s = 16'h0000;
    case (op_s)
      4'b0000, 4'b0001, 4'b0010, 4'b0011: alu_s = ap_s;
      4'b0100: alu_s = sum_s[15:0];
      4'b0101: alu_s = ap_s & bp_s;
      4'b0110: alu_s = ap_s;
      4'b0111: alu_s = ap_s ^ bp_s;
      4'b1011: alu_s = bit_reverse(ap_s);
      4'b1100: alu_s = {15'h0000, (sum_s[15:0] == 16'h0000)};
      4'b1101: alu_s = {15'h0000, ($signed(a_s) < $signed(b_s))};
      4'b1110: alu_s = {15'h0000, ($signed(a_s) <= $signed(b_s))};
      4'b1111: alu_s = {15'h0000, sum_s[16]};
      default: alu_s = 16'h0000;
    endcase
  end

  // Shift datapath step and selection of the value loaded into result
  always_comb begin
    step_s = shift_step(op_r[1:0], work_r);
    if (state_r == SHIFT) begin
      final_s = step_s;
    end else begin
      final_s = alu_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_s = IDLE;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (is_shift(op) && (b[3:0] != 4'd0)) begin
            next_s = SHIFT;
          end else begin
            next_s = DONE;
          end
        end else begin
          next_s = IDLE;
        end
      end
      SHIFT: begin
        if (count_r == 4'd1) begin
          next_s = DONE;
        end else begin
          next_s = SHIFT;
        end
      end
      DONE:    next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // State, operand latch, shift working register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= 16'h0000;
      cout    <= 1'b0;
      ofl     <= 1'b0;
      zero    <= 1'b0;
      op_r    <= 4'd0;
      inv_a_r <= 1'b0;
      inv_b_r <= 1'b0;
      cin_r   <= 1'b0;
      a_r     <= 16'h0000;
      b_r     <= 16'h0000;
      work_r  <= 16'h0000;
      count_r <= 4'd0;
    end else begin
      state_r <= next_s;
      busy    <= (next_s != IDLE);
      done    <= (next_s == DONE);
      if ((state_r == IDLE) && start) begin
        op_r    <= op;
        inv_a_r <= inv_a;
        inv_b_r <= inv_b;
        cin_r   <= cin;
        a_r     <= a;
        b_r     <= b;
        work_r  <= ap_s;
        count_r <= b[3:0];
      end else if (state_r == SHIFT) begin
        work_r  <= step_s;
        count_r <= count_r - 4'd1;
      end
      if (next_s == DONE) begin
        result <= final_s;
        cout   <= sum_s[16];
        ofl    <= ofl_s;
        zero   <= (final_s == 16'h0000);
      end
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: per-transaction arithmetic model compared every cycle,
// plus directed literal checks on latency, boundaries, start-while-busy and reset abort.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        rst, start, inv_a, inv_b, cin;
  logic [3:0]  op;
  logic [15:0] a, b;
  logic        busy, done, cout, ofl, zero;
  logic [15:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  alu_exec dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .inv_a(inv_a), .inv_b(inv_b),
    .cin(cin), .a(a), .b(b), .busy(busy), .done(done), .result(result),
    .cout(cout), .ofl(ofl), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: result {ofl, cout, result[15:0]} computed with plain integer arithmetic
  function automatic logic [17:0] ref_calc(input logic [3:0] o, input logic ia, input logic ib,
                                           input logic ci, input logic [15:0] av, input logic [15:0] bv);
    logic [15:0] ta, tb;
    int ap, bp, s, sa, sb, ss, k, r, ra, rb;
    logic c, v;
    ta = ia ? ~av : av;
    tb = ib ? ~bv : bv;
    ap = int'(ta);
    bp = int'(tb);
    s  = ap + bp + int'(ci);
    c  = ((s >> 16) & 1) != 0;
    sa = (ap >= 32768) ? ap - 65536 : ap;
    sb = (bp >= 32768) ? bp - 65536 : bp;
    ss = sa + sb + int'(ci);
    v  = (ss > 32767) || (ss < -32768);
    ra = (int'(av) >= 32768) ? int'(av) - 65536 : int'(av);
    rb = (int'(bv) >= 32768) ? int'(bv) - 65536 : int'(bv);
    k  = int'(bv[3:0]);
    r  = 0;
    case (o)
      4'd0:  r = ((ap << k) | (ap >> (16 - k))) & 65535;
      4'd1:  r = (ap << k) & 65535;
      4'd2:  r = ((ap >> k) | (ap << (16 - k))) & 65535;
      4'd3:  r = ap >> k;
      4'd4:  r = s & 65535;
      4'd5:  r = ap & bp;
      4'd6:  r = ap;
      4'd7:  r = ap ^ bp;
      4'd11: for (int i = 0; i < 16; i++) r = r | (((ap >> i) & 1) << (15 - i));
      4'd12: r = ((s & 65535) == 0) ? 1 : 0;
      4'd13: r = (ra < rb) ? 1 : 0;
      4'd14: r = (ra <= rb) ? 1 : 0;
      4'd15: r = c ? 1 : 0;
      default: r = 0;
    endcase
    return {v, c, r[15:0]};
  endfunction

  // Model state: cycles of busy remaining, expected outputs, pending values for a shift
  int          m_rem = 0;
  bit          m_valid = 1'b0;
  logic        e_busy = 1'b0, e_done = 1'b0, e_cout = 1'b0, e_ofl = 1'b0, e_zero = 1'b0;
  logic [15:0] e_res = 16'h0000;
  logic [17:0] p_val = 18'h0;

  always @(posedge clk) begin
    logic [17:0] rv;
    int k;
    if (rst) begin
      m_rem <= 0; e_busy <= 1'b0; e_done <= 1'b0; e_res <= 16'h0000;
      e_cout <= 1'b0; e_ofl <= 1'b0; e_zero <= 1'b0; m_valid <= 1'b1;
    end else if (m_rem == 0) begin
      if (start) begin
        rv = ref_calc(op, inv_a, inv_b, cin, a, b);
        k  = (op < 4'd4) ? int'(b[3:0]) : 0;
        m_rem  <= k + 1;
        e_busy <= 1'b1;
        if (k == 0) begin
          e_done <= 1'b1; e_res <= rv[15:0]; e_cout <= rv[16]; e_ofl <= rv[17];
          e_zero <= (rv[15:0] == 16'h0000);
        end else begin
          e_done <= 1'b0; p_val <= rv;
        end
      end else begin
        e_busy <= 1'b0; e_done <= 1'b0;
      end
    end else begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        e_busy <= 1'b0; e_done <= 1'b0;
      end else if (m_rem == 2) begin
        e_done <= 1'b1; e_res <= p_val[15:0]; e_cout <= p_val[16]; e_ofl <= p_val[17];
        e_zero <= (p_val[15:0] == 16'h0000);
      end else begin
        e_done <= 1'b0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (m_valid) begin
      cmp("busy", 32'(busy), 32'(e_busy));
      cmp("done", 32'(done), 32'(e_done));
      cmp("result", 32'(result), 32'(e_res));
      cmp("cout", 32'(cout), 32'(e_cout));
      cmp("ofl", 32'(ofl), 32'(e_ofl));
      cmp("zero", 32'(zero), 32'(e_zero));
    end
  end

  task automatic issue(input logic [3:0] o, input logic ia, input logic ib, input logic ci,
                       input logic [15:0] av, input logic [15:0] bv);
    @(negedge clk);
    op = o; inv_a = ia; inv_b = ib; cin = ci; a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = 4'($urandom); inv_a = 1'($urandom); inv_b = 1'($urandom); cin = 1'($urandom);
    a = 16'($urandom); b = 16'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: no done within %0d cycles", lat);
    end
  endtask

  initial begin
    int lat, n_done, done_lat;
    rst = 1'b1; start = 1'b0; op = 4'd0; inv_a = 1'b0; inv_b = 1'b0; cin = 1'b0;
    a = 16'h0000; b = 16'h0000;
    repeat (3) @(negedge clk);
    cmp("rst_busy", 32'(busy), 32'd0);
    cmp("rst_done", 32'(done), 32'd0);
    cmp("rst_result", 32'(result), 32'h0);
    cmp("rst_flags", {29'd0, cout, ofl, zero}, 32'd0);
    rst = 1'b0;

    issue(4'b0100, 1'b0, 1'b0, 1'b0, 16'h7FFF, 16'h0001);
    wait_done(lat);
    cmp("add_lat", 32'(lat), 32'd1);
    cmp("add_result", 32'(result), 32'h8000);
    cmp("add_flags", {29'd0, cout, ofl, zero}, 32'b010);

    issue(4'b0100, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0001);
    wait_done(lat);
    cmp("addc_result", 32'(result), 32'h0000);
    cmp("addc_flags", {29'd0, cout, ofl, zero}, 32'b101);

    issue(4'b0000, 1'b0, 1'b0, 1'b0, 16'h8001, 16'h0004);
    cmp("rol_busy", 32'(busy), 32'd1);
    cmp("rol_nodone", 32'(done), 32'd0);
    wait_done(lat);
    cmp("rol_lat", 32'(lat), 32'd5);
    cmp("rol_result", 32'(result), 32'h0018);

    issue(4'b0011, 1'b0, 1'b0, 1'b0, 16'hF000, 16'h000F);
    wait_done(lat);
    cmp("srl15_lat", 32'(lat), 32'd16);
    cmp("srl15_result", 32'(result), 32'h0001);

    issue(4'b0011, 1'b0, 1'b0, 1'b0, 16'hF000, 16'h0000);
    wait_done(lat);
    cmp("srl0_lat", 32'(lat), 32'd1);
    cmp("srl0_result", 32'(result), 32'hF000);

    issue(4'b1101, 1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0001);
    wait_done(lat);
    cmp("slt_result", 32'(result), 32'h0001);

    issue(4'b1100, 1'b1, 1'b0, 1'b1, 16'h0001, 16'h0001);
    wait_done(lat);
    cmp("seq_result", 32'(result), 32'h0001);
    cmp("seq_zero", 32'(zero), 32'd0);

    issue(4'b0010, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0008);
    n_done = 0; done_lat = 0;
    for (int l = 1; l <= 14; l++) begin
      if (l > 1) @(negedge clk);
      if (l == 2) begin
        start = 1'b1; op = 4'b0100;
      end
      if (l == 3) start = 1'b0;
      if (done === 1'b1) begin
        n_done++; done_lat = l;
      end
    end
    cmp("ror_ndone", 32'(n_done), 32'd1);
    cmp("ror_lat", 32'(done_lat), 32'd9);
    cmp("ror_result", 32'(result), 32'h3412);

    issue(4'b0001, 1'b0, 1'b0, 1'b0, 16'h0003, 16'h000A);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    cmp("abort_busy", 32'(busy), 32'd0);
    cmp("abort_done", 32'(done), 32'd0);
    cmp("abort_result", 32'(result), 32'h0);
    cmp("abort_flags", {29'd0, cout, ofl, zero}, 32'd0);
    rst = 1'b0;
    n_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    cmp("abort_nodone", 32'(n_done), 32'd0);
    issue(4'b0100, 1'b0, 1'b0, 1'b1, 16'h0010, 16'h0020);
    wait_done(lat);
    cmp("post_lat", 32'(lat), 32'd1);
    cmp("post_result", 32'(result), 32'h0031);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      op    = 4'($urandom_range(0, 15));
      inv_a = 1'($urandom); inv_b = 1'($urandom); cin = 1'($urandom);
      a     = 16'($urandom); b = 16'($urandom);
      if ($urandom_range(0, 3) == 0) a = ($urandom_range(0, 1) == 0) ? 16'h8000 : 16'h7FFF;
      rst   = ($urandom_range(0, 149) == 0);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (20) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 start  input  1  request to execute one operation; sampled only in IDLE.
REQ-004 op  input  4  ALU operation code, driven by ALU_OP decode stage.
REQ-005 inv_a  input  1  invert operand A before use.
REQ-006 inv_b  input  1  invert operand B before use.
REQ-007 cin  input  1  carry-in to adder.
REQ-008 a  input  16  operand A.
REQ-009 b  input  16  operand B; b[3:0] is shift/rotate amount.
REQ-010 busy  output  1  high whenever FSM is not IDLE.
REQ-011 done  output  1  single-cycle pulse; result and flags valid that cycle.
REQ-012 result  output  16  registered result; holds until next done.
REQ-013 cout  output  1  registered adder carry-out.
REQ-014 ofl  output  1  registered signed overflow of adder.
REQ-015 zero  output  1  registered (result == 0).

Function
REQ-016 On start in IDLE, op, inv_a, inv_b, cin, a, b SHALL be latched; later input changes have no effect on that operation.
REQ-017 A' = inv_a ? ~a : a; B' = inv_b ? ~b : b; sum = A' + B' + cin, 17 bits; cout = sum[16]; ofl = (A'[15]==B'[15]) && (sum[15]!=A'[15]).
REQ-018 Op map: 0000 ROL, 0001 SLL, 0010 ROR, 0011 SRL (by b[3:0]); 0100 sum[15:0]; 0101 A'&B'; 0110 A' (pass); 0111 A'^B'; 1011 bit-reverse of A'; 1100 SEQ: 1 if sum[15:0]==0; 1101 SLT: 1 if signed(a)<signed(b); 1110 SLE: 1 if signed(a)<=signed(b); 1111 SCO: cout zero-extended; 1000/1001/1010 result 0.
REQ-019 SEQ/SLT/SLE/SCO SHALL produce 16'h0000 or 16'h0001.
REQ-020 FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-021 IDLE: start=0 -> IDLE; start=1 and (op is shift/rotate with b[3:0]!=0) -> SHIFT with count=b[3:0]; else -> DONE.
REQ-022 SHIFT: one 1-bit step of the latched shift/rotate per cycle on internal working register, count decrements; count reaching 0 after the step -> DONE.
REQ-023 DONE: result, cout, ofl, zero loaded; done=1 for exactly this cycle; -> IDLE unconditionally.
REQ-024 Latency: start at cycle N -> done at N+1 for non-shift ops or amount 0; done at N+1+k for shift amount k (1..15).
REQ-025 start while busy (SHIFT or DONE) SHALL be ignored, not queued; minimum issue interval 2 cycles.
REQ-026 Shift amount 0 SHALL return A' unchanged; rotate wraps bit 15<->bit 0; SLL/SRL fill zeros.
REQ-027 cout/ofl SHALL be loaded from the adder for every op (including non-add); zero from final result.

Reset
REQ-028 rst=1 SHALL force state IDLE, busy=0, done=0, result=16'h0000, cout=0, ofl=0, zero=0, count=0 on next edge.
REQ-029 rst during SHIFT or DONE SHALL abort the operation with no done pulse; rst has priority over start in same cycle.

Verification
REQ-030 op=0100, a=16'h7FFF, b=16'h0001, cin=0, start@N -> done@N+1, result=16'h8000, ofl=1, cout=0, zero=0.
REQ-031 op=0000 ROL, a=16'h8001, b=16'h0004, start@N -> busy N+1..N+4, done@N+5, result=16'h0018.
REQ-032 op=0011 SRL, a=16'hF000, b=16'h000F -> done@N+16, result=16'h0001; same with b=0 -> done@N+1, result=16'hF000.
REQ-033 op=1101 SLT, inv_a=1, cin=1, a=16'hFFFF (-1), b=16'h0001 -> result=16'h0001; a=16'h0001, b=16'h0001 with op=1100 -> result=16'h0001, zero=0.
REQ-034 start pulsed again at N+2 during 8-bit ROR -> ignored, exactly one done at N+9.
REQ-035 rst asserted at N+3 during 10-bit SLL -> busy=0 and outputs zero at N+4, no done pulse; subsequent start works normally.
